re: RTL and testbench

RE

---
 rtl/re.sv | 234 +++++++++++++++++++++++
 tb/tb_re.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/re.sv
`default_nettype none
// ============================================================================
// Module   : re
// Brief    : Three-reel slot spin controller. Reels step on a divided tick,
//            stop one after another on latched targets, then the credit
//            display counts up by the pending win.
// Revision : 1.0
// ============================================================================
module re #(
  parameter int STEP_DIV       = 4,
  parameter int MIN_SPIN_STEPS = 20,
  parameter int STAGGER_STEPS  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_spin,
  input  logic [3:0]  reel1_idx,
  input  logic [3:0]  reel2_idx,
  input  logic [3:0]  reel3_idx,
  input  logic [11:0] win_credits,
  input  logic        is_win,
  input  logic [11:0] total_credits,
  input  logic        is_total,
  output logic [3:0]  reel1_pos,
  output logic [3:0]  reel2_pos,
  output logic [3:0]  reel3_pos,
  output logic [2:0]  reel_stopped,
  output logic        spinning,
  output logic [11:0] disp_credits,
  output logic        win_flash,
  output logic        done
);

  localparam int CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PMAX = (MIN_SPIN_STEPS > STAGGER_STEPS) ? MIN_SPIN_STEPS : STAGGER_STEPS;
  localparam int PW   = $clog2(PMAX + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 1);
  localparam logic [PW-1:0] SPIN_LAST = PW'(MIN_SPIN_STEPS - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(STAGGER_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SPIN = 3'd1,
    REL1 = 3'd2,
    GAP1 = 3'd3,
    REL2 = 3'd4,
    GAP2 = 3'd5,
    REL3 = 3'd6,
    SHOW = 3'd7
  } state_t;

  state_t          state;
  logic [CW-1:0]   step_cnt;
  logic [PW-1:0]   phase_cnt;
  logic            start_prev;
  logic            start_armed;
  logic [3:0]      tgt1, tgt2, tgt3;
  logic [11:0]     win_pend;
  logic            win_valid;
  logic [11:0]     win_goal;

  logic            tick;
  logic            start_edge;
  logic            spin_start;
  logic            reel_live;
  logic            stop1, stop2, stop3;
  logic            adv1, adv2, adv3;
  logic            show_done;
  logic [12:0]     win_sum;
  logic [11:0]     show_goal;

  // A level already high when reset releases must not count as an edge,
  // so edges are only honoured once start_spin has been seen low.
  assign tick       = (step_cnt == STEP_LAST);
  assign start_edge = start_spin & ~start_prev & start_armed;
  assign spin_start = (state == IDLE) && start_edge;
  assign reel_live  = (state != IDLE);

  assign stop1 = tick && (state == REL1) && (reel1_pos == tgt1);
  assign stop2 = tick && (state == REL2) && (reel2_pos == tgt2);
  assign stop3 = tick && (state == REL3) && (reel3_pos == tgt3);
  assign adv1  = tick && reel_live && !reel_stopped[0] && !stop1;
  assign adv2  = tick && reel_live && !reel_stopped[1] && !stop2;
  assign adv3  = tick && reel_live && !reel_stopped[2] && !stop3;

  assign show_done = (state == SHOW) && tick && (disp_credits == win_goal);

  // Saturating goal; without a valid non-zero win the goal is the current count.
  assign win_sum   = {1'b0, disp_credits} + {1'b0, win_pend};
  assign show_goal = (win_valid && (win_pend != 12'd0))
                   ? (win_sum[12] ? 12'hFFF : win_sum[11:0])
                   : disp_credits;

  // Free-running step divider, restarted when a spin begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= '0;
    end else if (spin_start || tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Start-level history for edge detection, tracked in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev  <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_prev <= start_spin;
      if (!start_spin) begin
        start_armed <= 1'b1;
      end
    end
  end

  // Target latch, reel stepping and stop flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt1         <= 4'd0;
      tgt2         <= 4'd0;
      tgt3         <= 4'd0;
      reel1_pos    <= 4'd0;
      reel2_pos    <= 4'd0;
      reel3_pos    <= 4'd0;
      reel_stopped <= 3'b000;
    end else if (spin_start) begin
      tgt1         <= reel1_idx;
      tgt2         <= reel2_idx;
      tgt3         <= reel3_idx;
      reel_stopped <= 3'b000;
    end else begin
      if (adv1) reel1_pos <= reel1_pos + 4'd1;
      if (adv2) reel2_pos <= reel2_pos + 4'd1;
      if (adv3) reel3_pos <= reel3_pos + 4'd1;
      if (stop1) reel_stopped[0] <= 1'b1;
      if (stop2) reel_stopped[1] <= 1'b1;
      if (stop3) reel_stopped[2] <= 1'b1;
    end
  end

  // Pending win; a new strobe takes priority over the end-of-show clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_pend  <= 12'd0;
      win_valid <= 1'b0;
    end else if (is_win) begin
      win_pend  <= win_credits;
      win_valid <= 1'b1;
    end else if (show_done) begin
      win_valid <= 1'b0;
    end
  end

  // Sequencer with registered status outputs and the credit display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      win_goal     <= 12'd0;
      disp_credits <= 12'd0;
      spinning     <= 1'b0;
      win_flash    <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (is_total) disp_credits <= total_credits;
          if (start_edge) begin
            state     <= SPIN;
            spinning  <= 1'b1;
            phase_cnt <= '0;
          end
        end
        SPIN: begin
          if (tick) begin
            if (phase_cnt == SPIN_LAST) begin
              state     <= REL1;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end
        REL1: if (stop1) state <= GAP1;
        GAP1: begin
          if (tick) begin
            if (phase_cnt == GAP_LAST) begin
              state     <= REL2;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end
        REL2: if (stop2) state <= GAP2;
        GAP2: begin
          if (tick) begin
            if (phase_cnt == GAP_LAST) begin
              state     <= REL3;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end
        REL3: begin
          if (stop3) begin
            state     <= SHOW;
            win_flash <= 1'b1;
            win_goal  <= show_goal;
          end
        end
        SHOW: begin
          if (tick) begin
            if (disp_credits == win_goal) begin
              state     <= IDLE;
              spinning  <= 1'b0;
              win_flash <= 1'b0;
              done      <= 1'b1;
            end else begin
              disp_credits <= disp_credits + 12'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_re.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_re
// Brief    : Self-checking bench for the reel spin controller; expected reel
//            stops and final credit state are queued per spin and compared as
//            the DUT reports them.
// Revision : 1.0
// ============================================================================
module tb_re;

  localparam int STEP_DIV = 4;
  localparam int MIN_SPIN = 20;
  localparam int STAGGER  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_spin = 1'b0;
  logic [3:0]  reel1_idx = 4'd0, reel2_idx = 4'd0, reel3_idx = 4'd0;
  logic [11:0] win_credits = 12'd0;
  logic        is_win = 1'b0;
  logic [11:0] total_credits = 12'd0;
  logic        is_total = 1'b0;
  logic [3:0]  reel1_pos, reel2_pos, reel3_pos;
  logic [2:0]  reel_stopped;
  logic        spinning;
  logic [11:0] disp_credits;
  logic        win_flash;
  logic        done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] mask;
    int         reel;
    logic [3:0] pos;
  } stop_t;

  stop_t       stop_q[$];
  logic [11:0] disp_q[$];
  int          flash_q[$];

  always #5 clk = ~clk;

  re #(
    .STEP_DIV      (STEP_DIV),
    .MIN_SPIN_STEPS(MIN_SPIN),
    .STAGGER_STEPS (STAGGER)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_spin   (start_spin),
    .reel1_idx    (reel1_idx),
    .reel2_idx    (reel2_idx),
    .reel3_idx    (reel3_idx),
    .win_credits  (win_credits),
    .is_win       (is_win),
    .total_credits(total_credits),
    .is_total     (is_total),
    .reel1_pos    (reel1_pos),
    .reel2_pos    (reel2_pos),
    .reel3_pos    (reel3_pos),
    .reel_stopped (reel_stopped),
    .spinning     (spinning),
    .disp_credits (disp_credits),
    .win_flash    (win_flash),
    .done         (done)
  );

  // Queue the expected outcome of one spin: stop order/positions, final
  // display value and win_flash length ((increments + exit tick) * STEP_DIV).
  task automatic push_spin(input logic [3:0] t1, input logic [3:0] t2,
                           input logic [3:0] t3, input logic [11:0] fin_disp,
                           input int n_inc);
    stop_t s;
    s.mask = 3'b001; s.reel = 1; s.pos = t1; stop_q.push_back(s);
    s.mask = 3'b011; s.reel = 2; s.pos = t2; stop_q.push_back(s);
    s.mask = 3'b111; s.reel = 3; s.pos = t3; stop_q.push_back(s);
    disp_q.push_back(fin_disp);
    flash_q.push_back((n_inc + 1) * STEP_DIV);
  endtask

  task automatic launch();
    @(negedge clk);
    start_spin = 1'b0;
    @(negedge clk);
    start_spin = 1'b1;
  endtask

  task automatic load_total(input logic [11:0] v);
    @(negedge clk);
    is_total = 1'b1;
    total_credits = v;
    @(negedge clk);
    is_total = 1'b0;
  endtask

  // Follow one spin to completion, scoring stops against the queue.
  task automatic observe(input string name, input int bound, input bit inj_win,
                         input logic [11:0] win_val, input bit inj_ignore);
    logic [2:0]  prev_stop;
    logic [11:0] prev_disp;
    logic [3:0]  p;
    logic [11:0] exp_d;
    int          exp_f;
    int          cyc, dones, flash, stop1_cyc, tail;
    bit          fin;
    stop_t       e;
    prev_stop = reel_stopped;
    prev_disp = disp_credits;
    cyc = 0; dones = 0; flash = 0; stop1_cyc = -1; tail = 0; fin = 1'b0;
    while (!fin && cyc < bound) begin
      @(negedge clk);
      cyc++;
      is_win = 1'b0;
      is_total = 1'b0;
      if (reel_stopped != prev_stop && reel_stopped != 3'b000) begin
        if (stop_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL %s unexpected_stop: reel_stopped=%b, expected no further stop", name, reel_stopped);
        end else begin
          e = stop_q.pop_front();
          checks++;
          if (reel_stopped !== e.mask) begin
            failures++;
            $display("FAIL %s stop_mask: got %b, expected %b", name, reel_stopped, e.mask);
          end
          p = (e.reel == 1) ? reel1_pos : (e.reel == 2) ? reel2_pos : reel3_pos;
          checks++;
          if (p !== e.pos) begin
            failures++;
            $display("FAIL %s stop_pos reel%0d: got %h, expected %h", name, e.reel, p, e.pos);
          end
          if (e.reel == 1) stop1_cyc = cyc;
        end
      end
      prev_stop = reel_stopped;
      if (win_flash) begin
        flash++;
        if (disp_credits != prev_disp) begin
          checks++;
          if (disp_credits !== prev_disp + 12'd1) begin
            failures++;
            $display("FAIL %s count_step: got %h after %h, expected %h", name, disp_credits, prev_disp, prev_disp + 12'd1);
          end
        end
      end
      prev_disp = disp_credits;
      if (done) dones++;
      if (dones > 0) begin
        tail++;
        if (tail > 8) fin = 1'b1;
      end
      if (inj_win && stop1_cyc > 0 && cyc == stop1_cyc) begin
        is_win = 1'b1;
        win_credits = win_val;
      end
      if (inj_ignore && stop1_cyc > 0 && cyc == stop1_cyc + 30) start_spin = 1'b0;
      if (inj_ignore && stop1_cyc > 0 && cyc == stop1_cyc + 34) begin
        start_spin = 1'b1;
        is_total = 1'b1;
        total_credits = 12'h555;
      end
    end
    is_win = 1'b0;
    is_total = 1'b0;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL %s timeout: no done within %0d cycles", name, bound);
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d, expected 1", name, dones);
    end
    exp_d = disp_q.pop_front();
    exp_f = flash_q.pop_front();
    checks++;
    if (disp_credits !== exp_d) begin
      failures++;
      $display("FAIL %s final_disp: got %h, expected %h", name, disp_credits, exp_d);
    end
    checks++;
    if (flash != exp_f) begin
      failures++;
      $display("FAIL %s flash_cycles: got %0d, expected %0d", name, flash, exp_f);
    end
    checks++;
    if (stop_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_stops: got %0d pending, expected 0", name, stop_q.size());
      stop_q.delete();
    end
    checks++;
    if (spinning !== 1'b0) begin
      failures++;
      $display("FAIL %s spinning_after: got %b, expected 0", name, spinning);
    end
  endtask

  task automatic test_reset();
    start_spin = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({reel1_pos, reel2_pos, reel3_pos, reel_stopped, spinning, disp_credits, win_flash, done} !== 30'd0) begin
      failures++;
      $display("FAIL reset_hold: outputs got %h, expected 0",
               {reel1_pos, reel2_pos, reel3_pos, reel_stopped, spinning, disp_credits, win_flash, done});
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (spinning !== 1'b0) begin
      failures++;
      $display("FAIL reset_level_start: spinning got %b, expected 0", spinning);
    end
    checks++;
    if (reel1_pos !== 4'd0) begin
      failures++;
      $display("FAIL reset_level_reel: reel1_pos got %h, expected 0", reel1_pos);
    end
    start_spin = 1'b0;
  endtask

  task automatic test_mid_reset();
    load_total(12'h777);
    reel1_idx = 4'h5; reel2_idx = 4'h5; reel3_idx = 4'h5;
    launch();
    repeat (60) @(negedge clk);
    checks++;
    if (spinning !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_pre: spinning got %b, expected 1", spinning);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({reel1_pos, reel2_pos, reel3_pos, reel_stopped, spinning, disp_credits, win_flash, done} !== 30'd0) begin
      failures++;
      $display("FAIL mid_reset_async: outputs got %h, expected 0",
               {reel1_pos, reel2_pos, reel3_pos, reel_stopped, spinning, disp_credits, win_flash, done});
    end
    start_spin = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({reel1_pos, reel2_pos, reel3_pos, reel_stopped, spinning, disp_credits, win_flash, done} !== 30'd0) begin
      failures++;
      $display("FAIL mid_reset_after: outputs got %h, expected 0",
               {reel1_pos, reel2_pos, reel3_pos, reel_stopped, spinning, disp_credits, win_flash, done});
    end
  endtask

  task automatic test_total();
    @(negedge clk);
    is_total = 1'b1;
    total_credits = 12'h100;
    @(negedge clk);
    is_total = 1'b0;
    checks++;
    if (disp_credits !== 12'h100) begin
      failures++;
      $display("FAIL total_load: disp got %h, expected 100", disp_credits);
    end
    checks++;
    if (spinning !== 1'b0) begin
      failures++;
      $display("FAIL total_spinning: got %b, expected 0", spinning);
    end
  endtask

  task automatic test_spin_no_win();
    reel1_idx = 4'h3; reel2_idx = 4'h6; reel3_idx = 4'hF;
    push_spin(4'h3, 4'h6, 4'hF, 12'h100, 0);
    launch();
    observe("spin_no_win", 3000, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic test_win_gap1();
    reel1_idx = 4'h3; reel2_idx = 4'h6; reel3_idx = 4'hF;
    push_spin(4'h3, 4'h6, 4'hF, 12'h1AA, 12'hAA);
    launch();
    observe("win_gap1", 4000, 1'b1, 12'h0AA, 1'b0);
  endtask

  task automatic test_saturate();
    load_total(12'hFF0);
    @(negedge clk);
    is_win = 1'b1;
    win_credits = 12'h020;
    @(negedge clk);
    is_win = 1'b0;
    reel1_idx = 4'h0; reel2_idx = 4'h9; reel3_idx = 4'hA;
    push_spin(4'h0, 4'h9, 4'hA, 12'hFFF, 15);
    launch();
    observe("saturate", 3000, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic test_ignored();
    load_total(12'h200);
    reel1_idx = 4'h9; reel2_idx = 4'h2; reel3_idx = 4'h7;
    push_spin(4'h9, 4'h2, 4'h7, 12'h200, 0);
    launch();
    observe("ignored_in_rel2", 3000, 1'b0, 12'h000, 1'b1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_spin = 1'b0;
    @(negedge clk);
    reel1_idx = 4'h1; reel2_idx = 4'h1; reel3_idx = 4'h1;
    push_spin(4'h1, 4'h1, 4'h1, 12'h123, 0);
    start_spin = 1'b1;
    is_total = 1'b1;
    total_credits = 12'h123;
    @(negedge clk);
    is_total = 1'b0;
    checks++;
    if (disp_credits !== 12'h123) begin
      failures++;
      $display("FAIL b2b_total: disp got %h, expected 123", disp_credits);
    end
    checks++;
    if (spinning !== 1'b1) begin
      failures++;
      $display("FAIL b2b_spin: spinning got %b, expected 1", spinning);
    end
    observe("back_to_back", 3000, 1'b0, 12'h000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_total();
    test_spin_no_win();
    test_win_gap1();
    test_saturate();
    test_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
